// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Brief    : Shared types and constants for the PWM compare stage
//             (dead-time FSM state encoding, shadow-register select codes).
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Dead-time FSM states: settled low, rising dead band, settled high,
    // falling dead band.
    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_DT_R = 2'd1,
        S_HI   = 2'd2,
        S_DT_F = 2'd3
    } dt_state_t;

    // wr_sel encodings
    localparam logic SEL_DUTY = 1'b0;
    localparam logic SEL_TOP  = 1'b1;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_deadtime
//  Brief    : Non-overlapping PWM pair generator. Inserts DT_CYC cycles of
//             "both low" on every edge of the raw compare signal. Only
//             instantiated by pwm_compare_stage when DEADTIME_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int N      = 4,
    parameter int DT_CYC = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic pwm_o,
    output logic pwm_n_o
);

    // The band lasts DT_CYC cycles counted from the cycle after entry, so
    // the counter starts one below DT_CYC and the exit happens at zero.
    localparam logic [N-1:0] DT_LOAD = N'(DT_CYC - 1);

    dt_state_t      state_q, state_d;
    logic [N-1:0]   dt_q, dt_d;

    // State and dead-time counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_LO;
            dt_q    <= '0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        pwm_o   = 1'b0;
        pwm_n_o = 1'b0;
        case (state_q)
            S_LO: begin
                pwm_n_o = 1'b1;
                if (raw_i) begin
                    state_d = S_DT_R;
                    dt_d    = DT_LOAD;
                end
            end
            S_DT_R: begin
                if (!raw_i) begin
                    state_d = S_LO;
                end else if (dt_q == '0) begin
                    state_d = S_HI;
                end else begin
                    dt_d = dt_q - N'(1);
                end
            end
            S_HI: begin
                pwm_o = 1'b1;
                if (!raw_i) begin
                    state_d = S_DT_F;
                    dt_d    = DT_LOAD;
                end
            end
            S_DT_F: begin
                if (raw_i) begin
                    state_d = S_HI;
                end else if (dt_q == '0) begin
                    state_d = S_LO;
                end else begin
                    dt_d = dt_q - N'(1);
                end
            end
            default: begin
                state_d = S_LO;
            end
        endcase
    end

endmodule : pwm_deadtime
`default_nettype wire

// File: rtl/pwm_compare_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_compare_stage
//  Brief    : Compares an up/down counter value against a double-buffered
//             duty value; produces PWM, complementary PWM, period-wrap and
//             duty-match pulses and a sticky period irq.
//             Optional feature macro: DEADTIME_EN (non-overlapping outputs
//             with DT_CYC cycles of dead time via pwm_deadtime).
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_compare_stage
    import pwm_pkg::*;
#(
    parameter int N      = 4,
    parameter int DT_CYC = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] cnt_in,
    input  logic         cnt_up,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [N-1:0] wr_data,
    input  logic         irq_clr,
    output logic         pwm_out,
    output logic         pwm_n_out,
    output logic         match_pulse,
    output logic         wrap_pulse,
    output logic         irq
);

    // Dead time must fit the N-bit dead-time counter
    if ((DT_CYC < 1) || (DT_CYC > (2**N) - 1)) begin : g_dt_cyc_range
        $error("pwm_compare_stage: DT_CYC out of range 1..2^N-1");
    end

    logic [N-1:0] cnt_q;
    logic [N-1:0] duty_sh_q,  duty_sh_d;
    logic [N-1:0] duty_act_q, duty_act_d;
    logic [N-1:0] top_sh_q,   top_sh_d;
    logic [N-1:0] top_act_q,  top_act_d;
    logic         wrap_q, match_q, irq_q, irq_d;

    logic raw;
    logic change;
    logic wrap_c;
    logic match_c;
    logic wr_duty;
    logic wr_top;

    // A held counter must not re-fire events, so only act on a new value
    assign change  = (cnt_in != cnt_q);
    assign raw     = (cnt_in < duty_act_q);
    assign wrap_c  = change && (cnt_up ? (cnt_in == top_act_q) : (cnt_in == '0));
    assign match_c = change && (cnt_in == duty_act_q);
    assign wr_duty = wr_en && (wr_sel == SEL_DUTY);
    assign wr_top  = wr_en && (wr_sel == SEL_TOP);

    // Shadow/active update; a write coinciding with a wrap reaches the active copy
    always_comb begin
        duty_sh_d  = duty_sh_q;
        top_sh_d   = top_sh_q;
        duty_act_d = duty_act_q;
        top_act_d  = top_act_q;
        if (wr_duty) duty_sh_d = wr_data;
        if (wr_top)  top_sh_d  = wr_data;
        if (wrap_c) begin
            duty_act_d = duty_sh_d;
            top_act_d  = top_sh_d;
        end
        irq_d = wrap_c ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    end

    // Compare-stage state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            top_sh_q   <= '1;
            top_act_q  <= '1;
            wrap_q     <= 1'b0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_in;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            top_sh_q   <= top_sh_d;
            top_act_q  <= top_act_d;
            wrap_q     <= wrap_c;
            match_q    <= match_c;
            irq_q      <= irq_d;
        end
    end

    assign wrap_pulse  = wrap_q;
    assign match_pulse = match_q;
    assign irq         = irq_q;

`ifdef DEADTIME_EN
    pwm_deadtime #(
        .N      (N),
        .DT_CYC (DT_CYC)
    ) u_deadtime (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (raw),
        .pwm_o   (pwm_out),
        .pwm_n_o (pwm_n_out)
    );
`else
    logic pwm_q, pwm_n_q;

    // Plain complementary outputs, one cycle behind the compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b1;
        end else begin
            pwm_q   <= raw;
            pwm_n_q <= ~raw;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_n_out = pwm_n_q;
`endif

endmodule : pwm_compare_stage
`default_nettype wire
